exu_lsu_ctrl: RTL and testbench
===============================

# exu_lsu_ctrl

Load/store controller between the AGU command port and the DTCM.
- Forward each accepted AGU command to the DTCM.
- Keep an in-order queue of per-request metadata (itag, size, usign, read, address offset) for every outstanding request.
- Pair each DTCM response with the oldest queue entry, then align and sign/zero-extend load data and present it on the write-back/commit interface.
- Report outstanding count for EXU hazard/commit logic; detect responses that arrive with nothing outstanding.

## Interface
Parameters:
- XLEN, 32, data width (only 32 supported)
- DTCM_AW, 16, DTCM byte-address width
- ITAG_W, 2, instruction tag width
- OUTS_DEPTH, 2, max outstanding requests (power of 2, ≥2)

Ports (CW = clog2(OUTS_DEPTH+1)):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- agu_cmd_valid  in  1  AGU command valid
- agu_cmd_ready  out  1  AGU command accepted
- agu_cmd_addr  in  DTCM_AW  byte address
- agu_cmd_read  in  1  1 = load, 0 = store
- agu_cmd_wdata  in  XLEN  store data, already lane-replicated
- agu_cmd_wmask  in  XLEN/8  byte write mask
- agu_cmd_itag  in  ITAG_W  tag
- agu_cmd_size  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word
- agu_cmd_usign  in  1  zero-extend load
- dtcm_cmd_valid / dtcm_cmd_ready  out / in  1  DTCM command handshake
- dtcm_cmd_addr / read / wdata / wmask  out  DTCM_AW / 1 / XLEN / XLEN/8  forwarded command fields
- dtcm_rsp_valid / dtcm_rsp_ready  in / out  1  DTCM response handshake
- dtcm_rsp_rdata  in  XLEN  raw word-aligned read data
- dtcm_rsp_err  in  1  bus error
- lsu_o_valid / lsu_o_ready  out / in  1  write-back/commit handshake
- lsu_o_wbck_wdat  out  XLEN  aligned load result; 0 for stores
- lsu_o_itag  out  ITAG_W  tag of completing request
- lsu_o_read  out  1  completing request was a load
- lsu_o_err  out  1  error of completing request
- lsu_outs_cnt  out  CW  requests outstanding
- lsu_idle  out  1  lsu_outs_cnt == 0
- lsu_proto_err  out  1  sticky flag: response arrived while queue was empty

## Operation
- Queue: circular FIFO of OUTS_DEPTH entries. Each entry holds {itag, size, usign, read, addr[1:0]}.
  - Write pointer, read pointer and count are registers.
  - full = (count == OUTS_DEPTH); empty = (count == 0).
- Command path (combinational pass-through):
  - dtcm_cmd_valid = agu_cmd_valid & ~full
  - agu_cmd_ready = dtcm_cmd_ready & ~full
  - dtcm command fields equal agu fields unmodified.
  - push = agu_cmd_valid & agu_cmd_ready.
- Response path:
  - When ~empty: lsu_o_valid = dtcm_rsp_valid; dtcm_rsp_ready = lsu_o_ready; pop = dtcm_rsp_valid & lsu_o_ready.
  - When empty: dtcm_rsp_ready = 1 and lsu_o_valid = 0. The response is dropped and lsu_proto_err sets.
- Load alignment, using head entry offset o = addr[1:0]:
  - Byte: b = rdata[8*o+7 : 8*o]; extend b[7] unless usign.
  - Half: h = rdata[16*o[1]+15 : 16*o[1]]; extend h[15] unless usign.
  - Word/11: rdata unchanged.
- Stores: lsu_o_wbck_wdat = 0.
- lsu_o_itag / read / err come from the head entry; err = dtcm_rsp_err.
- Count: next = count + push − pop. Simultaneous push and pop leaves count unchanged and advances both pointers.
- A pop while full does not enable a push in the same cycle: agu_cmd_ready has no path from lsu_o_ready.
- Pointers wrap modulo OUTS_DEPTH.
- lsu_proto_err clears only on rst.

## Timing
- Reset values: count, pointers and lsu_proto_err = 0.
- Resulting outputs after reset:
  - lsu_idle = 1, lsu_outs_cnt = 0.
  - agu_cmd_ready = dtcm_cmd_ready.
  - lsu_o_valid = 0; dtcm_rsp_ready = 1 (queue empty).
  - Other outputs follow their inputs combinationally.
- rst asserted mid-operation discards all outstanding entries immediately. Later responses to those requests count as spurious.
- Command latency: 0 cycles (combinational).
- Queue entry visible at the head on the cycle after push. A response in the same cycle as its own command's push is illegal for the DTCM.
- Response-to-write-back latency: 0 cycles (combinational).
- Throughput: one push and one pop per cycle.
- Valid/ready rules: once raised, valid must not drop before the handshake. The block holds lsu_o_valid and data stable while dtcm_rsp_valid is held.

## Test plan
- Signed byte load, addr offset 3, rdata 0x8012_3456:
  - lb → wdat 0xFFFF_FF80.
  - Same with usign = 1 → 0x0000_0080.
  - In both cases lsu_o_itag equals the issued tag and lsu_o_read = 1.
- Half load, offset 2, rdata 0x8012_3456:
  - lh → 0xFFFF_8012; lhu → 0x0000_8012.
  - Store response → wdat 0, lsu_o_read = 0.
- Full queue, OUTS_DEPTH 2:
  - Issue itags 1 and 2 with no responses → lsu_outs_cnt = 2.
  - Third command → agu_cmd_ready = 0, dtcm_cmd_valid = 0.
  - First response completes itag 1; cmd_ready rises the next cycle.
- Backpressure: lsu_o_ready = 0 with a response pending → dtcm_rsp_ready = 0, count unchanged. Release → pop in that cycle.
- Spurious response with empty queue → dtcm_rsp_ready = 1, lsu_o_valid = 0, lsu_proto_err = 1 from the next cycle and held.
- Reset mid-operation: one request outstanding, pulse rst asynchronously → lsu_outs_cnt = 0, lsu_idle = 1, lsu_proto_err = 0 immediately.

Source files
------------

// File: rtl/exu_lsu_ctrl.sv
// Load/store controller: forwards AGU commands to the DTCM, tracks outstanding requests
// in order, and aligns/extends load responses for write-back.
module exu_lsu_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DTCM_AW    = 16,
  parameter int unsigned ITAG_W     = 2,
  parameter int unsigned OUTS_DEPTH = 2,
  localparam int unsigned CW        = $clog2(OUTS_DEPTH + 1),
  localparam int unsigned PW        = $clog2(OUTS_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                agu_cmd_valid,
  output logic                agu_cmd_ready,
  input  logic [DTCM_AW-1:0]  agu_cmd_addr,
  input  logic                agu_cmd_read,
  input  logic [XLEN-1:0]     agu_cmd_wdata,
  input  logic [XLEN/8-1:0]   agu_cmd_wmask,
  input  logic [ITAG_W-1:0]   agu_cmd_itag,
  input  logic [1:0]          agu_cmd_size,
  input  logic                agu_cmd_usign,
  output logic                dtcm_cmd_valid,
  input  logic                dtcm_cmd_ready,
  output logic [DTCM_AW-1:0]  dtcm_cmd_addr,
  output logic                dtcm_cmd_read,
  output logic [XLEN-1:0]     dtcm_cmd_wdata,
  output logic [XLEN/8-1:0]   dtcm_cmd_wmask,
  input  logic                dtcm_rsp_valid,
  output logic                dtcm_rsp_ready,
  input  logic [XLEN-1:0]     dtcm_rsp_rdata,
  input  logic                dtcm_rsp_err,
  output logic                lsu_o_valid,
  input  logic                lsu_o_ready,
  output logic [XLEN-1:0]     lsu_o_wbck_wdat,
  output logic [ITAG_W-1:0]   lsu_o_itag,
  output logic                lsu_o_read,
  output logic                lsu_o_err,
  output logic [CW-1:0]       lsu_outs_cnt,
  output logic                lsu_idle,
  output logic                lsu_proto_err
);

  typedef struct packed {
    logic [ITAG_W-1:0] itag;
    logic [1:0]        size;
    logic              usign;
    logic              read;
    logic [1:0]        off;
  } ent_t;

  ent_t          q_mem [OUTS_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          perr_q, perr_d;
  logic          full, empty, push, pop;
  ent_t          head;
  logic [XLEN-1:0] sh_b, sh_h;

  assign full  = (cnt_q == CW'(OUTS_DEPTH));
  assign empty = (cnt_q == '0);

  assign dtcm_cmd_valid = agu_cmd_valid & ~full;
  assign agu_cmd_ready  = dtcm_cmd_ready & ~full;
  assign dtcm_cmd_addr  = agu_cmd_addr;
  assign dtcm_cmd_read  = agu_cmd_read;
  assign dtcm_cmd_wdata = agu_cmd_wdata;
  assign dtcm_cmd_wmask = agu_cmd_wmask;
  assign push           = agu_cmd_valid & agu_cmd_ready;

  // With nothing outstanding, responses are swallowed and flagged as protocol errors.
  assign lsu_o_valid    = ~empty & dtcm_rsp_valid;
  assign dtcm_rsp_ready = empty | lsu_o_ready;
  assign pop            = ~empty & dtcm_rsp_valid & lsu_o_ready;

  assign head       = q_mem[rd_ptr_q];
  assign lsu_o_itag = head.itag;
  assign lsu_o_read = head.read;
  assign lsu_o_err  = dtcm_rsp_err;

  assign sh_b = dtcm_rsp_rdata >> {head.off, 3'b000};
  assign sh_h = dtcm_rsp_rdata >> {head.off[1], 4'b0000};

  always_comb begin
    lsu_o_wbck_wdat = '0;
    if (head.read) begin
      unique case (head.size)
        2'b00:   lsu_o_wbck_wdat = {{(XLEN-8){sh_b[7] & ~head.usign}}, sh_b[7:0]};
        2'b01:   lsu_o_wbck_wdat = {{(XLEN-16){sh_h[15] & ~head.usign}}, sh_h[15:0]};
        default: lsu_o_wbck_wdat = dtcm_rsp_rdata;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    perr_d   = perr_q | (empty & dtcm_rsp_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      perr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      perr_q   <= perr_d;
    end
  end

  // Entry payload needs no reset: it is only observed once the count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr_q] <= '{itag:  agu_cmd_itag,
                           size:  agu_cmd_size,
                           usign: agu_cmd_usign,
                           read:  agu_cmd_read,
                           off:   agu_cmd_addr[1:0]};
    end
  end

  assign lsu_outs_cnt  = cnt_q;
  assign lsu_idle      = empty;
  assign lsu_proto_err = perr_q;

endmodule

// File: tb/tb_exu_lsu_ctrl.sv
// Directed and randomized bench for exu_lsu_ctrl against a queue-based reference model.
module tb_exu_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        agu_cmd_valid, agu_cmd_ready, agu_cmd_read, agu_cmd_usign;
  logic [15:0] agu_cmd_addr;
  logic [31:0] agu_cmd_wdata;
  logic [3:0]  agu_cmd_wmask;
  logic [1:0]  agu_cmd_itag, agu_cmd_size;
  logic        dtcm_cmd_valid, dtcm_cmd_ready, dtcm_cmd_read;
  logic [15:0] dtcm_cmd_addr;
  logic [31:0] dtcm_cmd_wdata;
  logic [3:0]  dtcm_cmd_wmask;
  logic        dtcm_rsp_valid, dtcm_rsp_ready, dtcm_rsp_err;
  logic [31:0] dtcm_rsp_rdata;
  logic        lsu_o_valid, lsu_o_ready, lsu_o_read, lsu_o_err;
  logic [31:0] lsu_o_wbck_wdat;
  logic [1:0]  lsu_o_itag, lsu_outs_cnt;
  logic        lsu_idle, lsu_proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exu_lsu_ctrl dut (
    .clk(clk), .rst(rst),
    .agu_cmd_valid(agu_cmd_valid), .agu_cmd_ready(agu_cmd_ready),
    .agu_cmd_addr(agu_cmd_addr), .agu_cmd_read(agu_cmd_read),
    .agu_cmd_wdata(agu_cmd_wdata), .agu_cmd_wmask(agu_cmd_wmask),
    .agu_cmd_itag(agu_cmd_itag), .agu_cmd_size(agu_cmd_size),
    .agu_cmd_usign(agu_cmd_usign),
    .dtcm_cmd_valid(dtcm_cmd_valid), .dtcm_cmd_ready(dtcm_cmd_ready),
    .dtcm_cmd_addr(dtcm_cmd_addr), .dtcm_cmd_read(dtcm_cmd_read),
    .dtcm_cmd_wdata(dtcm_cmd_wdata), .dtcm_cmd_wmask(dtcm_cmd_wmask),
    .dtcm_rsp_valid(dtcm_rsp_valid), .dtcm_rsp_ready(dtcm_rsp_ready),
    .dtcm_rsp_rdata(dtcm_rsp_rdata), .dtcm_rsp_err(dtcm_rsp_err),
    .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready),
    .lsu_o_wbck_wdat(lsu_o_wbck_wdat), .lsu_o_itag(lsu_o_itag),
    .lsu_o_read(lsu_o_read), .lsu_o_err(lsu_o_err),
    .lsu_outs_cnt(lsu_outs_cnt), .lsu_idle(lsu_idle), .lsu_proto_err(lsu_proto_err)
  );

  typedef struct {
    logic [1:0] itag;
    logic [1:0] size;
    logic       usign;
    logic       read;
    logic [1:0] off;
  } m_ent_t;

  m_ent_t q[$];
  bit     perr_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load result from the byte lanes the request addressed, extended arithmetically.
  function automatic logic [31:0] exp_wdat(input m_ent_t e, input logic [31:0] rd);
    int unsigned v;
    if (!e.read) return 32'd0;
    case (e.size)
      2'd0: begin
        v = (rd >> (8 * e.off)) & 32'hFF;
        if (!e.usign && v >= 128) v = v - 256;
      end
      2'd1: begin
        v = (rd >> (16 * (e.off / 2))) & 32'hFFFF;
        if (!e.usign && v >= 32768) v = v - 65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic check_all();
    bit full = (q.size() == 2);
    check("cmd_ready", agu_cmd_ready, dtcm_cmd_ready && !full);
    check("cmd_valid", dtcm_cmd_valid, agu_cmd_valid && !full);
    check("cmd_fields", {dtcm_cmd_addr, dtcm_cmd_read, dtcm_cmd_wmask},
          {agu_cmd_addr, agu_cmd_read, agu_cmd_wmask});
    check("cmd_wdata", dtcm_cmd_wdata, agu_cmd_wdata);
    check("rsp_ready", dtcm_rsp_ready, (q.size() == 0) || lsu_o_ready);
    check("o_valid", lsu_o_valid, (q.size() != 0) && dtcm_rsp_valid);
    check("outs_cnt", lsu_outs_cnt, q.size());
    check("idle", lsu_idle, q.size() == 0);
    check("proto_err", lsu_proto_err, perr_m);
    if (q.size() != 0 && dtcm_rsp_valid) begin
      check("o_itag", lsu_o_itag, q[0].itag);
      check("o_read", lsu_o_read, q[0].read);
      check("o_err", lsu_o_err, dtcm_rsp_err);
      check("o_wdat", lsu_o_wbck_wdat, exp_wdat(q[0], dtcm_rsp_rdata));
    end
  endtask

  // Called at a falling edge with inputs set; checks, then advances the model one cycle.
  task automatic step();
    bit push, pop, spur;
    m_ent_t e;
    #1;
    check_all();
    push = agu_cmd_valid && dtcm_cmd_ready && (q.size() < 2);
    pop  = (q.size() > 0) && dtcm_rsp_valid && lsu_o_ready;
    spur = (q.size() == 0) && dtcm_rsp_valid;
    e = '{itag: agu_cmd_itag, size: agu_cmd_size, usign: agu_cmd_usign,
          read: agu_cmd_read, off: agu_cmd_addr[1:0]};
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(e);
    if (spur) perr_m = 1'b1;
    @(negedge clk);
  endtask

  task automatic issue(input logic [15:0] addr, input logic rd, input logic [1:0] tag,
                       input logic [1:0] sz, input logic us);
    agu_cmd_valid = 1'b1; agu_cmd_addr = addr; agu_cmd_read = rd; agu_cmd_itag = tag;
    agu_cmd_size = sz; agu_cmd_usign = us; dtcm_cmd_ready = 1'b1; dtcm_rsp_valid = 1'b0;
    step();
    agu_cmd_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rd);
    dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = rd; lsu_o_ready = 1'b1; dtcm_rsp_err = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    agu_cmd_valid = 0; agu_cmd_addr = 0; agu_cmd_read = 0; agu_cmd_wdata = 0;
    agu_cmd_wmask = 0; agu_cmd_itag = 0; agu_cmd_size = 0; agu_cmd_usign = 0;
    dtcm_cmd_ready = 0; dtcm_rsp_valid = 0; dtcm_rsp_rdata = 0; dtcm_rsp_err = 0;
    lsu_o_ready = 0;
    @(negedge clk);
    #1;
    check("rst_idle", lsu_idle, 1'b1);
    check("rst_rsp_ready", dtcm_rsp_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    step();

    // Signed/unsigned byte at offset 3
    issue(16'h0103, 1'b1, 2'd1, 2'd0, 1'b0);
    respond(32'h8012_3456);
    check("lb", lsu_o_wbck_wdat, 32'hFFFF_FF80);
    check("lb_itag", lsu_o_itag, 2'd1);
    step(); dtcm_rsp_valid = 1'b0;
    issue(16'h0103, 1'b1, 2'd2, 2'd0, 1'b1);
    respond(32'h8012_3456);
    check("lbu", lsu_o_wbck_wdat, 32'h0000_0080);
    check("lbu_read", lsu_o_read, 1'b1);
    step(); dtcm_rsp_valid = 1'b0;

    // Half at offset 2, then a store
    issue(16'h0042, 1'b1, 2'd3, 2'd1, 1'b0);
    respond(32'h8012_3456);
    check("lh", lsu_o_wbck_wdat, 32'hFFFF_8012);
    step(); dtcm_rsp_valid = 1'b0;
    issue(16'h0042, 1'b1, 2'd0, 2'd1, 1'b1);
    respond(32'h8012_3456);
    check("lhu", lsu_o_wbck_wdat, 32'h0000_8012);
    step(); dtcm_rsp_valid = 1'b0;
    agu_cmd_wdata = 32'hCAFE_F00D; agu_cmd_wmask = 4'hF;
    issue(16'h0010, 1'b0, 2'd2, 2'd2, 1'b0);
    respond(32'hDEAD_BEEF);
    check("st_wdat", lsu_o_wbck_wdat, 32'h0);
    check("st_read", lsu_o_read, 1'b0);
    step(); dtcm_rsp_valid = 1'b0;

    // Fill the queue; a pop while full must not admit a push in the same cycle
    issue(16'h0000, 1'b1, 2'd1, 2'd2, 1'b0);
    issue(16'h0004, 1'b1, 2'd2, 2'd2, 1'b0);
    agu_cmd_valid = 1'b1; agu_cmd_itag = 2'd3;
    #1;
    check("full_cnt", lsu_outs_cnt, 2'd2);
    check("full_ready", agu_cmd_ready, 1'b0);
    check("full_cvalid", dtcm_cmd_valid, 1'b0);
    respond(32'h1111_1111);
    check("full_pop_itag", lsu_o_itag, 2'd1);
    check("full_pop_ready", agu_cmd_ready, 1'b0);
    step(); dtcm_rsp_valid = 1'b0;
    #1;
    check("ready_after_pop", agu_cmd_ready, 1'b1);
    step();
    agu_cmd_valid = 1'b0;
    respond(32'h2222_2222); step();
    respond(32'h3333_3333); step();
    dtcm_rsp_valid = 1'b0;

    // Backpressure on write-back
    issue(16'h0008, 1'b1, 2'd1, 2'd2, 1'b0);
    dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'h0BAD_CAFE; lsu_o_ready = 1'b0;
    #1;
    check("bp_rsp_ready", dtcm_rsp_ready, 1'b0);
    step(); step();
    lsu_o_ready = 1'b1;
    step();
    dtcm_rsp_valid = 1'b0;

    // Spurious response
    dtcm_rsp_valid = 1'b1;
    step();
    dtcm_rsp_valid = 1'b0;
    #1;
    check("perr_set", lsu_proto_err, 1'b1);
    step(); step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      agu_cmd_valid  = $urandom_range(0, 1);
      agu_cmd_addr   = 16'($urandom);
      agu_cmd_read   = $urandom_range(0, 3) != 0;
      agu_cmd_wdata  = $urandom;
      agu_cmd_wmask  = 4'($urandom);
      agu_cmd_itag   = 2'($urandom);
      agu_cmd_size   = 2'($urandom);
      agu_cmd_usign  = $urandom_range(0, 1);
      dtcm_cmd_ready = $urandom_range(0, 3) != 0;
      dtcm_rsp_valid = (q.size() > 0) ? ($urandom_range(0, 1) == 1)
                                      : ($urandom_range(0, 31) == 0);
      dtcm_rsp_rdata = $urandom;
      dtcm_rsp_err   = $urandom_range(0, 7) == 0;
      lsu_o_ready    = $urandom_range(0, 3) != 0;
      step();
    end

    // Asynchronous reset with a request outstanding
    agu_cmd_valid = 1'b0; dtcm_rsp_valid = 1'b0;
    if (q.size() == 0) issue(16'h0001, 1'b1, 2'd2, 2'd0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_cnt", lsu_outs_cnt, 2'd0);
    check("arst_idle", lsu_idle, 1'b1);
    check("arst_perr", lsu_proto_err, 1'b0);
    q.delete();
    perr_m = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    step();
    dtcm_rsp_valid = 1'b1;
    step();
    dtcm_rsp_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
